// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: 4x4 keypad column scanner with synchronized rows, press/release debounce
// and a valid/ack key-code handshake with sticky overrun.
module keypad_scan_controller #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    input  logic       key_ack,
    output logic [3:0] col_out,
    output logic [1:0] column_index,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       overrun
);
    localparam int DW = $clog2(SCAN_DWELL);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_meta_q, row_sync_q;
    logic [3:0]    pat_q, pat_d, col_q, col_d, code_q, code_d;
    logic [1:0]    idx_q, idx_d, row_idx;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d, held_q, held_d, ovr_q, ovr_d;
    logic          accept, advance;

    assign row_idx = pat_q[0] ? 2'd0 : pat_q[1] ? 2'd1 : pat_q[2] ? 2'd2 : 2'd3;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        col_d   = col_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;
        held_d  = held_q;
        ovr_d   = ovr_q;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + 1'b1;
                end else if (row_sync_q == 4'd0) begin
                    advance = 1'b1;
                end else begin
                    pat_d   = row_sync_q;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (row_sync_q != pat_q) begin
                    advance = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (row_sync_q == 4'd0) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            default: begin
                if (row_sync_q != 4'd0) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    advance = 1'b1;
                    held_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        if (advance) begin
            col_d   = {col_q[2:0], col_q[3]};
            idx_d   = idx_q + 1'b1;
            dwell_d = '0;
            state_d = SCAN;
        end
        if (key_ack && valid_q) valid_d = 1'b0;
        // A coincident ack frees the slot, so the new key loads instead of overrunning.
        if (accept) begin
            held_d = 1'b1;
            if (!valid_q || key_ack) begin
                code_d  = {row_idx, idx_q};
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            row_meta_q <= '0;
            row_sync_q <= '0;
            pat_q      <= '0;
            col_q      <= 4'b0001;
            idx_q      <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            pat_q      <= pat_d;
            col_q      <= col_d;
            idx_q      <= idx_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
            ovr_q      <= ovr_d;
        end
    end

    assign col_out      = col_q;
    assign column_index = idx_q;
    assign key_code     = code_q;
    assign key_valid    = valid_q;
    assign key_held     = held_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: keypad model driving rows per driven column; expected key codes are
// queued at press time and compared when the controller accepts the key.
module tb_keypad_scan_controller;
    localparam int SD = 4;
    localparam int DB = 4;

    logic       slow_clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic       key_ack;
    logic [3:0] col_out;
    logic [1:0] column_index;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       overrun;

    logic       key_down;
    logic [3:0] key_col;
    logic [3:0] key_rows;
    logic [3:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    keypad_scan_controller #(.SCAN_DWELL(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .slow_clk(slow_clk), .rst(rst), .row_in(row_in), .key_ack(key_ack),
        .col_out(col_out), .column_index(column_index), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .overrun(overrun)
    );

    always #5 slow_clk = ~slow_clk;

    // A pressed key only shorts its row lines while its own column is driven.
    assign row_in = (key_down && col_out == key_col) ? key_rows : 4'b0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input int n);
        logic [3:0] e;
        for (int k = 0; k < n; k++) begin
            e = 4'b0001 << ((k / SD) % 4);
            check("idle_col", col_out, e);
            check("idle_idx", column_index, (k / SD) % 4);
            check("idle_valid", key_valid, 0);
            check("idle_held", key_held, 0);
            check("idle_ovr", overrun, 0);
            @(negedge slow_clk);
        end
    endtask

    task automatic wait_col(input logic [3:0] c);
        int n = 0;
        while (col_out != c && n < 64) begin
            @(negedge slow_clk);
            n++;
        end
        if (n >= 64) check("wait_col_timeout", col_out, c);
    endtask

    task automatic pulse_ack(input logic ovr);
        check("ack_pre_valid", key_valid, 1);
        key_ack = 1'b1;
        @(negedge slow_clk);
        key_ack = 1'b0;
        check("ack_valid_drop", key_valid, 0);
        check("ack_ovr", overrun, ovr);
    endtask

    task automatic press(input logic [3:0] col, input logic [3:0] rows, input logic [3:0] nxt,
                         input logic [1:0] nxt_idx, input logic [3:0] code, input logic ovr,
                         input logic coinc, input logic rel);
        int n = 0;
        logic [3:0] e;
        exp_q.push_back(code);
        while (col_out == col && n < 64) begin
            @(negedge slow_clk);
            n++;
        end
        key_col  = col;
        key_rows = rows;
        key_down = 1'b1;
        wait_col(col);
        n = 0;
        while (!key_held && n < 40) begin
            key_ack = coinc && (n == SD + DB - 1);
            @(negedge slow_clk);
            n++;
        end
        key_ack = 1'b0;
        check("press_latency", n, SD + DB);
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("key_code", key_code, e);
        end
        check("press_valid", key_valid, 1);
        check("press_ovr", overrun, ovr);
        check("press_frozen", col_out, col);
        if (rel) begin
            repeat (8) @(negedge slow_clk);
            check("hold_col", col_out, col);
            check("hold_held", key_held, 1);
            key_down = 1'b0;
            repeat (6) @(negedge slow_clk);
            check("rel_still_held", key_held, 1);
            check("rel_still_col", col_out, col);
            @(negedge slow_clk);
            check("rel_held_drop", key_held, 0);
            check("rel_next_col", col_out, nxt);
            check("rel_next_idx", column_index, nxt_idx);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        key_ack  = 1'b0;
        key_down = 1'b0;
        key_col  = 4'b0001;
        key_rows = 4'b0000;
        repeat (3) @(negedge slow_clk);
        check("rst_col", col_out, 4'b0001);
        check("rst_idx", column_index, 0);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        idle_check(40);

        // Clean press on column 1, row 2, then ack.
        press(4'b0010, 4'b0100, 4'b0100, 2'd2, 4'b1001, 1'b0, 1'b0, 1'b1);
        pulse_ack(1'b0);

        // Bounce on column 0: the row drops mid-debounce, so nothing is accepted.
        while (col_out == 4'b0001) @(negedge slow_clk);
        key_col  = 4'b0001;
        key_rows = 4'b0001;
        key_down = 1'b1;
        wait_col(4'b0001);
        repeat (5) @(negedge slow_clk);
        key_down = 1'b0;
        repeat (3) @(negedge slow_clk);
        check("bounce_col", col_out, 4'b0010);
        check("bounce_valid", key_valid, 0);
        check("bounce_held", key_held, 0);
        repeat (4) @(negedge slow_clk);
        check("bounce_scan_on", col_out, 4'b0100);
        check("bounce_valid2", key_valid, 0);

        // Multi-row pattern on column 3; release wraps to column 0.
        press(4'b1000, 4'b0110, 4'b0001, 2'd0, 4'b0111, 1'b0, 1'b0, 1'b1);
        pulse_ack(1'b0);

        // Handshake: A unacked, B accepted with coincident ack, C overruns.
        press(4'b0001, 4'b0010, 4'b0010, 2'd1, 4'b0100, 1'b0, 1'b0, 1'b1);
        press(4'b0010, 4'b1000, 4'b0100, 2'd2, 4'b1101, 1'b0, 1'b1, 1'b1);
        press(4'b0100, 4'b0001, 4'b1000, 2'd3, 4'b1101, 1'b1, 1'b0, 1'b1);
        pulse_ack(1'b1);

        // Reset while the key is still held in PRESSED.
        press(4'b1000, 4'b0100, 4'b0001, 2'd0, 4'b1011, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge slow_clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_col", col_out, 4'b0001);
        check("mid_rst_idx", column_index, 0);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_ovr", overrun, 0);
        key_down = 1'b0;
        @(negedge slow_clk);
        rst = 1'b0;
        idle_check(20);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequencing controller for the 4x4 matrix keypad. It drives the one-hot column strobe and dwells on each column long enough to sample the rows through a synchronizer. When a key is seen it freezes the scan, debounces press and release, and presents a 4-bit key code through a valid/ack handshake to the adder front-end. It supersedes free-running column rotation: the column advances only when this block allows it.

## Interface

Parameters:
- SCAN_DWELL, 4: cycles each column is driven while scanning; minimum 3, covering the 2-flop sync latency plus one cycle.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a press or a release; minimum 1.

Ports:
- slow_clk  in  1  scan clock (1 kHz); all state on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- row_in  in  4  raw keypad rows; active-high; asynchronous to slow_clk.
- key_ack  in  1  consumer accepts key_code; honoured only while key_valid=1.
- col_out  out  4  one-hot column drive.
- column_index  out  2  binary index of the driven column (bit position of col_out).
- key_code  out  4  {row_idx[1:0], column_index[1:0]} of the accepted key.
- key_valid  out  1  key_code holds an unconsumed key.
- key_held  out  1  an accepted key is still physically pressed.
- overrun  out  1  sticky; a key was accepted while key_valid=1.

## Operation

- row_in passes through a 2-flop synchronizer (row_sync). All decisions use row_sync only.
- Row encode: row_idx is the lowest set bit of the latched pattern (0110 gives 1).
- The state machine has four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - A dwell counter runs 0..SCAN_DWELL-1.
  - At dwell = SCAN_DWELL-1 with row_sync = 0: rotate col_out left (1000 wraps to 0001), increment column_index (3 wraps to 0), and reset dwell to 0.
  - At dwell = SCAN_DWELL-1 with row_sync != 0: latch row_sync as pat, clear the debounce counter, go to DEBOUNCE, and keep the column.
- DEBOUNCE (column frozen):
  - row_sync = pat: increment the counter.
  - On the DEBOUNCE_CYCLES-th consecutive match: accept the key and go to PRESSED.
  - row_sync != pat: abandon, rotate to the next column, dwell = 0, go to SCAN. Nothing is emitted.
- PRESSED (column frozen, key_held = 1):
  - row_sync = 0: clear the counter and go to RELEASE.
- RELEASE (column frozen, key_held = 1):
  - row_sync = 0 for DEBOUNCE_CYCLES consecutive cycles: rotate to the next column, dwell = 0, go to SCAN, key_held = 0.
  - row_sync != 0 before that: return to PRESSED. This is not a new key.
- Accept:
  - key_valid = 0: load key_code and set key_valid = 1.
  - key_valid = 1 and no ack this cycle: set overrun = 1 and leave key_code unchanged.
- Ack: key_ack = 1 while key_valid = 1 clears key_valid on the next edge. key_ack while key_valid = 0 is ignored.
- Accept and ack in the same cycle: the new code loads, key_valid stays 1, and overrun is not set.
- overrun clears only on rst.

## Timing

- Reset values:
  - col_out = 0001, column_index = 0
  - key_code = 0000, key_valid = 0, key_held = 0, overrun = 0
  - state SCAN, dwell = 0, synchronizer flops 0
- A rst assertion in any state returns every register to its reset value asynchronously. Scanning restarts at column 0 after release.
- col_out and column_index are registered and always change on the same edge. col_out is never zero and never multi-hot.
- A full idle sweep takes 4·SCAN_DWELL cycles (16 at defaults).
- Row latency: row_in to row_sync is 2 edges.
- Press latency: if DEBOUNCE is entered on cycle E, key_valid, key_code and key_held are first high on cycle E+DEBOUNCE_CYCLES.
- Release latency: if RELEASE is entered on cycle R, key_held drops and col_out advances on cycle R+DEBOUNCE_CYCLES.
- key_valid falls on the cycle after the ack cycle.

## Test plan

Each scenario uses default parameters unless noted.

- **Idle scan:** hold row_in = 0 for 40 cycles after rst.
  - col_out shows 0001×4, 0010×4, 0100×4, 1000×4, repeating.
  - column_index tracks it.
  - key_valid, key_held and overrun stay 0.
- **Clean press:** row_in = 0100 whenever col_out = 0010, held for 20 cycles, then 0.
  - col_out freezes at 0010.
  - key_code = 1001, key_valid = 1 and key_held = 1 exactly 4 cycles after DEBOUNCE entry.
  - After release, key_held falls 4 cycles into RELEASE and col_out becomes 0100.
- **Bounce:** row_in = 0001 on column 0, toggled to 0000 on the 2nd DEBOUNCE cycle.
  - No key_valid.
  - col_out advances to 0010 and scanning continues.
- **Multi-row and wrap:** row_in = 0110 on column 3 (col_out = 1000).
  - key_code = 0111.
  - After release, col_out wraps to 0001 and column_index to 0.
- **Handshake and overrun:** accept key A, no ack, then press and release key B.
  - overrun = 1 and key_code stays A.
  - Pulsing key_ack for 1 cycle drops key_valid on the next cycle; overrun stays 1.
  - Accept coincident with ack: the new code loads, key_valid stays 1, overrun unchanged.
- **Reset mid-operation:** assert rst while in PRESSED.
  - All outputs return to reset values immediately (col_out = 0001, key_valid = 0, overrun = 0).
  - Idle scan resumes after rst deasserts, with the key released.
